ifetch_ctrl: RTL and testbench

Instruction-fetch controller for the RISC-V core. It sits directly downstream of the 32-bit PC register and drives that register's `CE`. It takes the current PC and fetches the instruction word over a request/response instruction-memory port. It presents the word to decode with a valid/ready handshake and pulses `pc_ce` exactly when the PC may advance or must be redirected.

---
 rtl/rv_pkg.sv | 18 +
 rtl/ifetch_ctrl.sv | 104 ++++++++++
 tb/tb_ifetch_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP and the
// instruction-fetch controller state type.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } ifetch_state_t;

endpackage : rv_pkg

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: fetches the word at pc_in over a req/gnt/rvalid
// port, presents it to decode with valid/ready and drives the PC register's CE.
module ifetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INST = RV_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_ce,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  ifetch_state_t   state_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_fault_q;
  logic            misaligned;
  logic            fire;

  // Handshake and PC-enable decode; flush takes priority over a fire.
  assign misaligned = |pc_in[1:0];
  assign inst_valid = (state_q == S_HOLD);
  assign fire       = inst_valid & inst_ready & ~flush;
  assign pc_ce      = fire | flush;
  assign imem_req   = (state_q == S_REQ) & ~misaligned;
  assign imem_addr  = imem_req ? pc_in : '0;

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      inst_q       <= RESET_INST;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;

        // A misaligned PC under flush is stale; retry with the redirected PC.
        S_REQ: begin
          if (misaligned) begin
            if (!flush) begin
              inst_pc_q    <= pc_in;
              inst_q       <= RESET_INST;
              inst_fault_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (imem_gnt) begin
            inst_pc_q <= pc_in;
            state_q   <= flush ? S_DROP : S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            if (flush) begin
              inst_q  <= RESET_INST;
              state_q <= S_REQ;
            end else begin
              inst_q       <= imem_rdata;
              inst_fault_q <= 1'b0;
              state_q      <= S_HOLD;
            end
          end else if (flush) begin
            state_q <= S_DROP;
          end
        end

        S_HOLD: begin
          if (pc_ce) begin
            state_q <= S_REQ;
            if (flush) inst_q <= RESET_INST;
          end
        end

        // Exactly one response is still owed; swallow it.
        S_DROP: begin
          if (imem_rvalid) begin
            inst_q  <= RESET_INST;
            state_q <= S_REQ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule : ifetch_ctrl

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a transaction-level reference model and
// a local PC register fed by pc_ce.
module tb_ifetch_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, imem_gnt, imem_rvalid, inst_ready;
  logic        pc_ce, imem_req, inst_valid, inst_fault;
  logic [31:0] pc_in, imem_addr, imem_rdata, inst, inst_pc, tgt;

  int checks = 0;
  int errors = 0;

  // Reference model: what the fetch unit is doing, not how it is encoded
  bit          m_boot, m_hold, m_out, m_doom, m_fault;
  logic [31:0] m_inst, m_pc;

  // Outputs sampled on the falling edge of the current cycle
  logic        s_valid, s_req, s_pce, s_fault;
  logic [31:0] s_addr, s_inst, s_ipc, s_pc;

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_INST(RV_NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ce(pc_ce), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  // External PC register: sequential +4, or redirect target on flush
  always @(posedge clk) begin
    if (!rst) pc_in <= 32'h0;
    else if (pc_ce) pc_in <= flush ? tgt : pc_in + 32'd4;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    bit e_req;
    s_valid = inst_valid; s_req = imem_req; s_pce = pc_ce; s_fault = inst_fault;
    s_addr  = imem_addr;  s_inst = inst;   s_ipc = inst_pc; s_pc = pc_in;
    e_req = !m_boot && !m_hold && !m_out && (pc_in[1:0] == 2'b00);
    chk1("inst_valid", s_valid, m_hold);
    chk1("imem_req", s_req, e_req);
    chk32("imem_addr", s_addr, e_req ? pc_in : 32'h0);
    chk1("pc_ce", s_pce, flush | (m_hold & inst_ready));
    if (m_hold || m_boot) begin
      chk32("inst", s_inst, m_inst);
      chk32("inst_pc", s_ipc, m_pc);
      chk1("inst_fault", s_fault, m_fault);
    end
  endtask

  task automatic model_upd();
    if (!rst) begin
      m_boot = 1; m_hold = 0; m_out = 0; m_doom = 0;
      m_inst = RV_NOP; m_pc = 32'h0; m_fault = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_hold) begin
      if (flush || inst_ready) m_hold = 0;
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out = 0;
        if (!m_doom && !flush) begin
          m_hold = 1; m_inst = imem_rdata; m_fault = 0;
        end
        m_doom = 0;
      end else if (flush) begin
        m_doom = 1;
      end
    end else if (pc_in[1:0] != 2'b00) begin
      if (!flush) begin
        m_hold = 1; m_inst = RV_NOP; m_pc = pc_in; m_fault = 1;
      end
    end else if (imem_gnt) begin
      m_out = 1; m_pc = pc_in; m_doom = flush;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, step past the rising edge
  task automatic tick();
    @(negedge clk);
    model_cmp();
    model_upd();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    inst_ready = 1'b0; imem_rdata = 32'h0; tgt = 32'h0;
    m_boot = 1; m_hold = 0; m_out = 0; m_doom = 0;
    m_inst = RV_NOP; m_pc = 32'h0; m_fault = 0;
    @(posedge clk); #1;

    // Reset state
    tick();
    chk1("rst_valid", s_valid, 1'b0);
    chk1("rst_req", s_req, 1'b0);
    chk32("rst_inst", s_inst, 32'h0000_0013);
    rst = 1'b1;
    tick();

    // Minimum fetch loop at PC 0
    imem_gnt = 1; inst_ready = 1; tick();
    chk1("loop_c0_req", s_req, 1'b1);
    chk32("loop_c0_addr", s_addr, 32'h0);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093; tick();
    chk1("loop_c1_valid", s_valid, 1'b0);
    chk1("loop_c1_pce", s_pce, 1'b0);
    imem_rvalid = 0; tick();
    chk1("loop_c2_valid", s_valid, 1'b1);
    chk32("loop_c2_inst", s_inst, 32'h0050_0093);
    chk32("loop_c2_pc", s_ipc, 32'h0);
    chk1("loop_c2_pce", s_pce, 1'b1);
    inst_ready = 0; tick();
    chk1("loop_c3_req", s_req, 1'b1);
    chk32("loop_c3_addr", s_addr, 32'h4);
    chk1("loop_c3_pce", s_pce, 1'b0);

    // Backpressure in HOLD, with a stray rvalid that must be ignored
    imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00A0_0113; tick();
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = (i == 2); imem_rdata = 32'hBAD0_0000; tick();
      chk1("bp_valid", s_valid, 1'b1);
      chk32("bp_inst", s_inst, 32'h00A0_0113);
      chk32("bp_pc", s_ipc, 32'h4);
      chk1("bp_pce", s_pce, 1'b0);
      chk1("bp_req", s_req, 1'b0);
    end
    imem_rvalid = 0; inst_ready = 1; tick();
    chk1("bp_release_pce", s_pce, 1'b1);
    inst_ready = 0;

    // Redirect to 0x40, then hold grant low for three cycles
    imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0010_0193; tick();
    imem_rvalid = 0; flush = 1; tgt = 32'h40; tick();
    chk1("redir40_pce", s_pce, 1'b1);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("nognt_req", s_req, 1'b1);
      chk32("nognt_addr", s_addr, 32'h40);
    end
    imem_gnt = 1; tick();

    // Flush in WAIT; the late DEADBEEF response must be dropped
    imem_gnt = 0; flush = 1; tgt = 32'h100; tick();
    chk1("wflush_pce", s_pce, 1'b1);
    chk1("wflush_req", s_req, 1'b0);
    flush = 0; tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    chk1("drop_valid", s_valid, 1'b0);
    imem_rvalid = 0; tick();
    chk1("refetch_req", s_req, 1'b1);
    chk32("refetch_addr", s_addr, 32'h100);
    chk1("refetch_valid", s_valid, 1'b0);

    // Flush and ready together in HOLD: one pc_ce, redirect wins
    imem_gnt = 1; tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0020_0213; tick();
    imem_rvalid = 0; flush = 1; inst_ready = 1; tgt = 32'h102; tick();
    chk1("fr_valid", s_valid, 1'b1);
    chk1("fr_pce", s_pce, 1'b1);
    flush = 0; inst_ready = 0; tick();
    chk1("fr_after_pce", s_pce, 1'b0);
    chk32("fr_pc", s_pc, 32'h102);

    // Misaligned PC 0x102: fault presented without a memory request
    chk1("mis_req0", s_req, 1'b0);
    tick();
    chk1("mis_valid", s_valid, 1'b1);
    chk1("mis_fault", s_fault, 1'b1);
    chk32("mis_pc", s_ipc, 32'h102);
    chk32("mis_inst", s_inst, 32'h0000_0013);
    chk1("mis_req1", s_req, 1'b0);
    flush = 1; tgt = 32'h200; tick();
    chk1("mis_exit_pce", s_pce, 1'b1);
    flush = 0;

    // Reset asserted while waiting for a response
    imem_gnt = 1; tick();
    imem_gnt = 0; rst = 0; tick();
    rst = 1; tick();
    chk1("wrst_valid", s_valid, 1'b0);
    chk1("wrst_req", s_req, 1'b0);
    chk32("wrst_addr", s_addr, 32'h0);
    chk1("wrst_pce", s_pce, 1'b0);
    chk32("wrst_inst", s_inst, 32'h0000_0013);
    chk32("wrst_pc", s_ipc, 32'h0);
    chk1("wrst_fault", s_fault, 1'b0);

    // Recovery fetch after reset
    imem_gnt = 1; tick();
    chk1("rec_req", s_req, 1'b1);
    chk32("rec_addr", s_addr, 32'h0);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0030_0293; tick();
    imem_rvalid = 0; inst_ready = 1; tick();
    chk32("rec_inst", s_inst, 32'h0030_0293);
    chk1("rec_fault", s_fault, 1'b0);
    inst_ready = 0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifetch_ctrl
